// File: rtl/raster_stamp_dispatch_pkg.sv
// Raster stamp/CSR types shared by the stamp dispatcher and its FIFO.
package raster_stamp_dispatch_pkg;

    localparam int unsigned RASTER_DIM_BITS       = 12;
    localparam int unsigned RASTER_STAMP_DIM_BITS = RASTER_DIM_BITS - 1;
    localparam int unsigned RASTER_PID_BITS       = 16;
    localparam int unsigned RASTER_BCOORD_BITS    = 16;
    localparam int unsigned RASTER_NUM_BCOORDS    = 3;

    // Field placement inside the packed pos_mask CSR word
    localparam int unsigned RASTER_POSMASK_X_LSB = 4;
    localparam int unsigned RASTER_POSMASK_Y_LSB = RASTER_POSMASK_X_LSB + RASTER_STAMP_DIM_BITS;

    typedef logic [RASTER_NUM_BCOORDS-1:0][RASTER_BCOORD_BITS-1:0] raster_bcoords_t;

    typedef struct packed {
        logic [RASTER_STAMP_DIM_BITS-1:0] pos_x;
        logic [RASTER_STAMP_DIM_BITS-1:0] pos_y;
        logic [3:0]                       mask;
        raster_bcoords_t                  bcoords;
        logic [RASTER_PID_BITS-1:0]       pid;
    } raster_stamp_t;

    typedef struct packed {
        logic [31:0]     pos_mask;
        raster_bcoords_t bcoords;
    } raster_csrs_t;

    // Converts a stamp into the per-lane CSR view; unused pos_mask bits stay zero
    function automatic raster_csrs_t raster_pack_csrs(input raster_stamp_t stamp);
        raster_csrs_t csrs;
        csrs = '0;
        csrs.pos_mask[3:0] = stamp.mask;
        csrs.pos_mask[RASTER_POSMASK_X_LSB +: RASTER_STAMP_DIM_BITS] = stamp.pos_x;
        csrs.pos_mask[RASTER_POSMASK_Y_LSB +: RASTER_STAMP_DIM_BITS] = stamp.pos_y;
        csrs.bcoords = stamp.bcoords;
        return csrs;
    endfunction

endpackage

// File: rtl/raster_stamp_dispatch_fifo.sv
// Synchronous stamp FIFO with a registered first-word (head) output.
module raster_stamp_fifo
    import raster_stamp_dispatch_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  raster_stamp_t          data_i,
    input  logic                   pop_i,
    output raster_stamp_t          data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [PtrW:0]   CntOne = 1;
    localparam logic [PtrW:0]   CntFull = Depth[PtrW:0];

    raster_stamp_t   mem_q [Depth];
    raster_stamp_t   head_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [PtrW:0]   count_q;
    logic            push_en, pop_en;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = head_q;
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign rd_next = rd_ptr_q + PtrOne;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and the head register that presents the oldest entry
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_next;
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + CntOne;
            end else if (pop_en && !push_en) begin
                count_q <= count_q - CntOne;
            end
            // Incoming word becomes head when the queue is (or is about to be) empty
            if (push_en && (empty_o || (pop_en && count_q == CntOne))) begin
                head_q <= data_i;
            end else if (pop_en) begin
                head_q <= mem_q[rd_next];
            end
        end
    end

endmodule

// File: rtl/raster_stamp_dispatch.sv
// Hands queued raster stamps to the active lanes of warp fetch requests.
module raster_stamp_dispatch
    import raster_stamp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         stamp_valid_i,
    input  logic [$bits(raster_stamp_t)-1:0]             stamp_data_i,
    output logic                                         stamp_ready_o,
    input  logic                                         raster_done_i,
    input  logic                                         req_valid_i,
    input  logic [NUM_LANES-1:0]                         req_tmask_i,
    input  logic [TAG_WIDTH-1:0]                         req_tag_i,
    output logic                                         req_ready_o,
    output logic                                         rsp_valid_o,
    output logic [NUM_LANES-1:0]                         rsp_tmask_o,
    output logic [TAG_WIDTH-1:0]                         rsp_tag_o,
    output logic [NUM_LANES*$bits(raster_csrs_t)-1:0]    rsp_csrs_o,
    output logic [NUM_LANES*RASTER_PID_BITS-1:0]         rsp_pid_o,
    input  logic                                         rsp_ready_i
);

    if (RASTER_POSMASK_Y_LSB + RASTER_STAMP_DIM_BITS > 32) begin : gen_posmask_overflow
        $error("pos_mask packing does not fit in 32 bits");
    end

    typedef enum logic [1:0] {StIdle, StGather, StResp} state_e;

    state_e                                     state_q, state_d;
    logic                                       live_q;
    logic [NUM_LANES-1:0]                       remain_q, remain_d, lane_sel;
    logic [NUM_LANES-1:0]                       rsp_tmask_q, rsp_tmask_d;
    logic [TAG_WIDTH-1:0]                       tag_q, tag_d;
    raster_csrs_t [NUM_LANES-1:0]               csrs_q, csrs_d;
    logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0]  pid_q, pid_d;

    raster_stamp_t                  fifo_head;
    logic                           fifo_pop, fifo_full, fifo_empty, req_ready;
    logic [$clog2(QUEUE_DEPTH):0]   fifo_count;
    logic                           unused_count;

    assign unused_count = ^fifo_count;

    // live_q keeps both ready outputs low during reset and for the cycle after
    assign stamp_ready_o = live_q && !fifo_full;
    assign req_ready     = live_q && (state_q == StIdle);
    assign req_ready_o   = req_ready;
    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_tmask_o   = rsp_tmask_q;
    assign rsp_tag_o     = tag_q;
    assign rsp_csrs_o    = csrs_q;
    assign rsp_pid_o     = pid_q;

    // One-hot of the lowest lane still waiting for a stamp
    assign lane_sel = remain_q & (~remain_q + NUM_LANES'(1));

    raster_stamp_fifo #(
        .Depth (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (stamp_valid_i && stamp_ready_o),
        .data_i  (raster_stamp_t'(stamp_data_i)),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Request FSM and response datapath next-state
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        tag_d       = tag_q;
        rsp_tmask_d = rsp_tmask_q;
        csrs_d      = csrs_q;
        pid_d       = pid_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready) begin
                    remain_d    = req_tmask_i;
                    tag_d       = req_tag_i;
                    rsp_tmask_d = '0;
                    csrs_d      = '0;
                    pid_d       = '0;
                    state_d     = (req_tmask_i == '0) ? StResp : StGather;
                end
            end
            StGather: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (lane_sel[i]) begin
                            csrs_d[i]      = raster_pack_csrs(fifo_head);
                            pid_d[i]       = fifo_head.pid;
                            rsp_tmask_d[i] = 1'b1;
                        end
                    end
                    remain_d = remain_q & ~lane_sel;
                    if (remain_d == '0) begin
                        state_d = StResp;
                    end
                end else if (raster_done_i) begin
                    // Drained: respond with whatever lanes were filled
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            remain_q    <= '0;
            tag_q       <= '0;
            rsp_tmask_q <= '0;
            csrs_q      <= '0;
            pid_q       <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            remain_q    <= remain_d;
            tag_q       <= tag_d;
            rsp_tmask_q <= rsp_tmask_d;
            csrs_q      <= csrs_d;
            pid_q       <= pid_d;
        end
    end

endmodule

// File: tb/tb_raster_stamp_dispatch.sv
// Randomised scoreboard bench for raster_stamp_dispatch.
module tb_raster_stamp_dispatch;
    import raster_stamp_dispatch_pkg::*;

    localparam int unsigned NL  = 4;
    localparam int unsigned QD  = 8;
    localparam int unsigned TW  = 8;
    localparam int unsigned D   = RASTER_DIM_BITS - 1;
    localparam int unsigned PB  = RASTER_PID_BITS;
    localparam int unsigned CW  = $bits(raster_csrs_t);
    localparam int unsigned BCW = $bits(raster_bcoords_t);
    localparam int unsigned SW  = $bits(raster_stamp_t);

    typedef struct packed {
        logic [NL-1:0]          tmask;
        logic [TW-1:0]          tag;
        logic [NL-1:0][31:0]    pm;
        logic [NL-1:0][BCW-1:0] bc;
        logic [NL-1:0][PB-1:0]  pid;
    } exp_t;

    logic              clk, reset;
    logic              stamp_valid, stamp_ready, raster_done;
    logic [SW-1:0]     stamp_data;
    logic              req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NL-1:0]     req_tmask, rsp_tmask;
    logic [TW-1:0]     req_tag, rsp_tag;
    logic [NL*CW-1:0]  rsp_csrs;
    logic [NL*PB-1:0]  rsp_pid;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;  // 0 random, 1 hold low, 2 hold high

    raster_stamp_t model_q[$];  // stamps delivered to the DUT but not yet promised to a lane
    exp_t          exp_q[$];

    raster_stamp_dispatch #(
        .NUM_LANES   (NL),
        .QUEUE_DEPTH (QD),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .stamp_valid_i (stamp_valid),
        .stamp_data_i  (stamp_data),
        .stamp_ready_o (stamp_ready),
        .raster_done_i (raster_done),
        .req_valid_i   (req_valid),
        .req_tmask_i   (req_tmask),
        .req_tag_i     (req_tag),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_tmask_o   (rsp_tmask),
        .rsp_tag_o     (rsp_tag),
        .rsp_csrs_o    (rsp_csrs),
        .rsp_pid_o     (rsp_pid),
        .rsp_ready_i   (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] ref_posmask(input raster_stamp_t s);
        return 32'(s.mask) | (32'(s.pos_x) << 4) | (32'(s.pos_y) << (4 + D));
    endfunction

    function automatic raster_stamp_t rand_stamp();
        raster_stamp_t s;
        logic [63:0]   r;
        r         = {$urandom(), $urandom()};
        s.pos_x   = D'($urandom());
        s.pos_y   = D'($urandom());
        s.mask    = 4'($urandom());
        s.bcoords = r[BCW-1:0];
        s.pid     = PB'($urandom());
        return s;
    endfunction

    // Lanes in ascending order each take the next queued stamp; missing ones stay zero
    task automatic predict(input logic [NL-1:0] tm, input logic [TW-1:0] tag);
        exp_t          e;
        raster_stamp_t s;
        e     = '0;
        e.tag = tag;
        for (int l = 0; l < int'(NL); l++) begin
            if (tm[l] && model_q.size() > 0) begin
                s          = model_q.pop_front();
                e.tmask[l] = 1'b1;
                e.pm[l]    = ref_posmask(s);
                e.bc[l]    = s.bcoords;
                e.pid[l]   = s.pid;
            end
        end
        exp_q.push_back(e);
    endtask

    // Response monitor: compares every accepted response against the scoreboard
    initial begin
        exp_t         e;
        raster_csrs_t c;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got tmask %0h expected no response", rsp_tmask);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tmask", 64'(rsp_tmask), 64'(e.tmask));
                    chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    for (int l = 0; l < int'(NL); l++) begin
                        c = rsp_csrs[l*CW +: CW];
                        chk($sformatf("lane%0d_posmask", l), 64'(c.pos_mask), 64'(e.pm[l]));
                        chk($sformatf("lane%0d_bcoords", l), 64'(c.bcoords), 64'(e.bc[l]));
                        chk($sformatf("lane%0d_pid", l), 64'(rsp_pid[l*PB +: PB]), 64'(e.pid[l]));
                    end
                end
            end
        end
    end

    // rsp_ready driver
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       rsp_ready = 1'b0;
                2:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // All tasks below start and end at posedge+1
    task automatic drive_stamp(input raster_stamp_t s);
        int n;
        stamp_valid = 1'b1;
        stamp_data  = s;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (stamp_ready) break;
            @(posedge clk);
            #1;
        end
        if (n == 300) chk("stamp_push_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        stamp_valid = 1'b0;
    endtask

    task automatic push_stamp(input raster_stamp_t s);
        model_q.push_back(s);
        drive_stamp(s);
    endtask

    task automatic issue(input logic [NL-1:0] tm, input logic [TW-1:0] tag, input bit expect_it);
        int n;
        if (expect_it) predict(tm, tag);
        req_valid = 1'b1;
        req_tmask = tm;
        req_tag   = tag;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) break;
            @(posedge clk);
            #1;
        end
        if (n == 300) chk("req_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (lat > 0) chk(name, 64'(n), 64'(lat));
        else if (n > 200) chk(name, 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (req_ready && !rsp_valid) break;
        end
        if (n == 500) chk("idle_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        chk({p, "_stamp_ready"}, 64'(stamp_ready), 64'(0));
        chk({p, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({p, "_rsp_tmask"}, 64'(rsp_tmask), 64'(0));
        chk({p, "_rsp_tag"}, 64'(rsp_tag), 64'(0));
        chk({p, "_rsp_csrs"}, 64'(|rsp_csrs), 64'(0));
        chk({p, "_rsp_pid"}, 64'(|rsp_pid), 64'(0));
    endtask

    task automatic do_reset(input string p);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero(p);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        raster_done = 1'b0;
        model_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({p, "_req_ready_after"}, 64'(req_ready), 64'(1));
        chk({p, "_stamp_ready_after"}, 64'(stamp_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        raster_stamp_t s;
        raster_stamp_t st[4];
        reset       = 1'b1;
        stamp_valid = 1'b0;
        stamp_data  = '0;
        raster_done = 1'b0;
        req_valid   = 1'b0;
        req_tmask   = '0;
        req_tag     = '0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Full warp with four queued stamps
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            s       = rand_stamp();
            s.pos_x = D'(i + 1);
            s.mask  = 4'hF;
            push_stamp(s);
        end
        issue(4'b1111, 8'h5A, 1);
        wait_valid("lat_full", 5);
        rdy_mode = 2;
        wait_idle();

        // Sparse mask
        rdy_mode = 1;
        push_stamp(rand_stamp());
        push_stamp(rand_stamp());
        issue(4'b1010, 8'($urandom()), 1);
        wait_valid("lat_sparse", 3);
        rdy_mode = 2;
        wait_idle();

        // Partial fill then exhaustion
        rdy_mode = 0;
        push_stamp(rand_stamp());
        raster_done = 1'b1;
        issue(4'b1111, 8'h11, 1);
        wait_idle();
        issue(4'b1111, 8'h22, 1);
        wait_idle();
        rdy_mode = 1;
        issue(4'b0000, 8'h33, 1);
        wait_valid("lat_zero_mask", 1);
        rdy_mode = 0;
        wait_idle();

        // Random traffic with raster_done set
        for (int it = 0; it < 30; it++) begin
            int np;
            np = $urandom_range(0, QD - model_q.size());
            for (int k = 0; k < np; k++) push_stamp(rand_stamp());
            issue(NL'($urandom()), 8'($urandom()), 1);
            wait_idle();
        end

        do_reset("rst1");

        // Stall with empty FIFO until stamps trickle in
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            st[i] = rand_stamp();
            model_q.push_back(st[i]);
        end
        issue(4'b1111, 8'h44, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive_stamp(st[i]);
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Fill to full; a push during a pop from a full queue is refused
        for (int i = 0; i < int'(QD); i++) push_stamp(rand_stamp());
        @(negedge clk);
        chk("full_stamp_ready", 64'(stamp_ready), 64'(0));
        @(posedge clk);
        #1;
        issue(4'b0001, 8'h55, 1);
        stamp_valid = 1'b1;
        stamp_data  = rand_stamp();
        @(negedge clk);
        chk("full_pop_no_passthru", 64'(stamp_ready), 64'(0));
        @(posedge clk);
        #1;
        stamp_valid = 1'b0;
        wait_idle();
        raster_done = 1'b1;
        issue(4'b1111, 8'h66, 1);
        wait_idle();
        issue(4'b1111, 8'h77, 1);
        wait_idle();
        issue(4'b1111, 8'h88, 1);
        wait_idle();

        // Reset in the middle of a stalled gather
        do_reset("rst2");
        issue(4'b1111, 8'h99, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst_gather");

        // Reset while a response is held; leftover stamp must be flushed
        rdy_mode = 1;
        push_stamp(rand_stamp());
        push_stamp(rand_stamp());
        issue(4'b0001, 8'hAA, 0);
        wait_valid("held_rsp_seen", 0);
        do_reset("rst_resp");
        rdy_mode    = 2;
        raster_done = 1'b1;
        issue(4'b1111, 8'hBB, 1);
        wait_idle();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
